// File: rtl/digit_entry_register_pkg.sv
// rtl/digit_entry_register_pkg.sv - shared constants, state encoding and helpers for the digit entry register
// Contents: digit geometry, key-code constants, blank nibble, FSM state codes,
//           and a helper that turns a display word into a zero-filled operand.
package digit_entry_register_pkg;

  localparam int DIGITS  = 3;
  localparam int DIGIT_W = 4;
  localparam int WORD_W  = DIGITS * DIGIT_W;

  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

  localparam logic [DIGIT_W-1:0] KEY_CLEAR = 4'hA;
  localparam logic [DIGIT_W-1:0] KEY_BACK  = 4'hB;
  localparam logic [DIGIT_W-1:0] KEY_ENTER = 4'hC;

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_ENTRY  = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;
  localparam logic [1:0] ST_SUBMIT = 2'd3;

  localparam logic [WORD_W-1:0] BLANK_WORD = {DIGITS{BLANK_CODE}};

  // Blank nibbles only ever occupy unused positions, so mapping them to 0
  // yields the operand with leading zeros.
  function automatic logic [WORD_W-1:0] blank_to_zero(input logic [WORD_W-1:0] word);
    logic [WORD_W-1:0] res;
    res = word;
    for (int i = 0; i < DIGITS; i++) begin
      if (word[i*DIGIT_W +: DIGIT_W] == BLANK_CODE) begin
        res[i*DIGIT_W +: DIGIT_W] = '0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/digit_entry_register_key_edge_detect.sv
// rtl/digit_entry_register_key_edge_detect.sv - rising-edge detector for the keypad valid level
// Ports: clk, reset (sync, active-high), key_valid (level in), key_event (one-cycle pulse out).
// History resets to 1 so a key already held when reset releases produces no event.
module key_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic key_valid,
  output logic key_event
);

  logic key_valid_q;
  logic key_valid_d;

  always_comb begin
    key_valid_d = key_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid_q <= 1'b1;
    end else begin
      key_valid_q <= key_valid_d;
    end
  end

  assign key_event = key_valid & ~key_valid_q;

endmodule

// File: rtl/digit_entry_register.sv
// rtl/digit_entry_register.sv - keypad digit accumulator with display word and operand handshake
// Ports: clk, reset (sync, active-high); key_valid/key_code keypad input;
//        memory (display word, newest digit in [3:0]); digit_count (0..3);
//        operand_out/operand_valid/operand_ready operand handshake; overflow pulse.
module digit_entry_register
  import digit_entry_register_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [11:0] memory,
  output logic [1:0]  digit_count,
  output logic [11:0] operand_out,
  output logic        operand_valid,
  input  logic        operand_ready,
  output logic        overflow
);

  logic key_event;

  key_edge_detect u_key_edge_detect (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_event (key_event)
  );

  logic [1:0]  state_q,   state_d;
  logic [11:0] digits_q,  digits_d;
  logic [1:0]  count_q,   count_d;
  logic [11:0] operand_q, operand_d;
  logic        valid_q,   valid_d;
  logic        ovf_q,     ovf_d;

  logic is_digit;
  logic is_clear;

  assign is_digit = key_event & (key_code <= 4'd9);
  assign is_clear = key_event & (key_code == KEY_CLEAR);

  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    count_d   = count_q;
    operand_d = operand_q;
    valid_d   = valid_q;
    ovf_d     = 1'b0;

    if (is_clear) begin
      // Clear beats a simultaneous handshake completion in SUBMIT.
      digits_d = BLANK_WORD;
      count_d  = 2'd0;
      valid_d  = 1'b0;
      state_d  = ST_EMPTY;
    end else if (state_q == ST_SUBMIT) begin
      // Keys other than clear are ignored while the operand is on offer.
      if (valid_q && operand_ready) begin
        valid_d  = 1'b0;
        digits_d = BLANK_WORD;
        count_d  = 2'd0;
        state_d  = ST_EMPTY;
      end
    end else if (key_event) begin
      if (is_digit) begin
        if (state_q == ST_FULL) begin
          ovf_d = 1'b1;
        end else begin
          digits_d = {digits_q[7:0], key_code};
          count_d  = 2'(count_q + 2'd1);
          state_d  = (count_q == 2'd2) ? ST_FULL : ST_ENTRY;
        end
      end else if (key_code == KEY_BACK) begin
        if (state_q != ST_EMPTY) begin
          digits_d = {BLANK_CODE, digits_q[11:4]};
          count_d  = 2'(count_q - 2'd1);
          state_d  = (count_q == 2'd1) ? ST_EMPTY : ST_ENTRY;
        end
      end else if (key_code == KEY_ENTER) begin
        if (state_q != ST_EMPTY) begin
          operand_d = blank_to_zero(digits_q);
          valid_d   = 1'b1;
          state_d   = ST_SUBMIT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      digits_q  <= BLANK_WORD;
      count_q   <= 2'd0;
      operand_q <= 12'd0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      count_q   <= count_d;
      operand_q <= operand_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign memory        = digits_q;
  assign digit_count   = count_q;
  assign operand_out   = operand_q;
  assign operand_valid = valid_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_digit_entry_register.sv
// tb/tb_digit_entry_register.sv - directed self-checking bench for digit_entry_register
module tb_digit_entry_register;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] memory;
  logic [1:0]  digit_count;
  logic [11:0] operand_out;
  logic        operand_valid;
  logic        operand_ready;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  logic kv_prev = 1'b1;

  digit_entry_register dut (
    .clk           (clk),
    .reset         (reset),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .memory        (memory),
    .digit_count   (digit_count),
    .operand_out   (operand_out),
    .operand_valid (operand_valid),
    .operand_ready (operand_ready),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  // Acceptance scoreboard: a transfer completes on an edge with valid & ready,
  // unless a clear key event lands on the same edge.
  always @(posedge clk) begin
    if (!reset && operand_valid && operand_ready &&
        !(key_valid && !kv_prev && key_code == 4'hA)) begin
      n_acc++;
    end
    kv_prev <= reset ? 1'b1 : key_valid;
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presses a key for one cycle; returns at the negedge after the event edge.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem"},   memory, 12'hFFF);
    chk({tag, "_cnt"},   {10'd0, digit_count}, 12'd0);
    chk({tag, "_opnd"},  operand_out, 12'd0);
    chk({tag, "_valid"}, {11'd0, operand_valid}, 12'd0);
    chk({tag, "_ovf"},   {11'd0, overflow}, 12'd0);
  endtask

  initial begin
    reset = 1'b1;
    key_valid = 1'b1;
    key_code = 4'h4;
    operand_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_key_mem", memory, 12'hFFF);
    chk("held_key_cnt", {10'd0, digit_count}, 12'd0);
    key_valid = 1'b0;

    press(4'd4);  chk("p4_mem", memory, 12'hFF4);
                  chk("p4_cnt", {10'd0, digit_count}, 12'd1);
    press(4'd2);  chk("p2_mem", memory, 12'hF42);
    press(4'd7);  chk("p7_mem", memory, 12'h427);
                  chk("p7_cnt", {10'd0, digit_count}, 12'd3);
    press(4'd9);  chk("ovf_mem", memory, 12'h427);
                  chk("ovf_pulse", {11'd0, overflow}, 12'd1);
    @(negedge clk);
    chk("ovf_drop", {11'd0, overflow}, 12'd0);

    press(4'hB);  chk("bs1_mem", memory, 12'hF42);
                  chk("bs1_cnt", {10'd0, digit_count}, 12'd2);
    press(4'hB);  chk("bs2_mem", memory, 12'hFF4);
    press(4'hB);  chk("bs3_mem", memory, 12'hFFF);
                  chk("bs3_cnt", {10'd0, digit_count}, 12'd0);
    press(4'hB);  chk("bs4_mem", memory, 12'hFFF);
                  chk("bs4_cnt", {10'd0, digit_count}, 12'd0);

    press(4'hE);  chk("ignored_code", memory, 12'hFFF);

    press(4'd5);
    press(4'd8);
    press(4'hC);  chk("ent_opnd", operand_out, 12'h058);
                  chk("ent_valid", {11'd0, operand_valid}, 12'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_valid", {11'd0, operand_valid}, 12'd1);
    end
    press(4'd3);  chk("sub_mem", memory, 12'hF58);
                  chk("sub_cnt", {10'd0, digit_count}, 12'd2);
                  chk("sub_valid", {11'd0, operand_valid}, 12'd1);
    operand_ready = 1'b1;
    @(negedge clk);
    operand_ready = 1'b0;
    chk("acc_valid", {11'd0, operand_valid}, 12'd0);
    chk("acc_mem", memory, 12'hFFF);
    chk("acc_cnt", {10'd0, digit_count}, 12'd0);
    chk("acc_opnd", operand_out, 12'h058);
    chk("acc_count1", n_acc[11:0], 12'd1);

    @(negedge clk);
    chk("rdy_idle_valid", {11'd0, operand_valid}, 12'd0);

    press(4'd1);
    press(4'hC);  chk("e2_opnd", operand_out, 12'h001);
                  chk("e2_valid", {11'd0, operand_valid}, 12'd1);
    @(negedge clk);
    key_valid = 1'b1;
    key_code = 4'hA;
    operand_ready = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    operand_ready = 1'b0;
    chk("clr_valid", {11'd0, operand_valid}, 12'd0);
    chk("clr_mem", memory, 12'hFFF);
    chk("clr_cnt", {10'd0, digit_count}, 12'd0);
    chk("clr_acc", n_acc[11:0], 12'd1);

    press(4'hC);  chk("enter_empty", {11'd0, operand_valid}, 12'd0);

    press(4'd6);
    press(4'hC);  chk("e3_valid", {11'd0, operand_valid}, 12'd1);
                  chk("e3_opnd", operand_out, 12'h006);
    @(negedge clk);
    reset = 1'b1;
    key_valid = 1'b1;
    key_code = 4'd7;
    @(negedge clk);
    chk_reset_vals("rst_sub");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_held_mem", memory, 12'hFFF);
    chk("rst_held_cnt", {10'd0, digit_count}, 12'd0);
    key_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
